// File: rtl/inta_sequencer_if.sv
// rtl/inta_sequencer_if.sv - PIC/CPU-side signal bundle for the INTA sequencer
//
// Purpose: groups the interrupt request, INTA strobe, PIC data bus and the
// CPU vector handshake into one interface so that the sequencer and its
// neighbours connect through a single port.
//
// Signals:
//   int_in        PIC INT, active high
//   cpu_int_en    CPU interrupt-enable flag; 0 blocks new sequences
//   data_bus_in   PIC data bus, sampled at the end of pulse 2
//   inta_n        registered INTA to the PIC, active low
//   vector        captured interrupt vector
//   vector_valid  vector holds an unconsumed value
//   vector_ready  CPU accepts the vector
//   busy          sequencer is not idle
//
// Modports:
//   master  the sequencer itself (drives inta_n, vector, vector_valid, busy)
//   slave   the PIC/CPU environment around it
interface inta_sequencer_if;
  logic       int_in;
  logic       cpu_int_en;
  logic [7:0] data_bus_in;
  logic       inta_n;
  logic [7:0] vector;
  logic       vector_valid;
  logic       vector_ready;
  logic       busy;

  modport master (
    input  int_in,
    input  cpu_int_en,
    input  data_bus_in,
    input  vector_ready,
    output inta_n,
    output vector,
    output vector_valid,
    output busy
  );

  modport slave (
    output int_in,
    output cpu_int_en,
    output data_bus_in,
    output vector_ready,
    input  inta_n,
    input  vector,
    input  vector_valid,
    input  busy
  );
endinterface

// File: rtl/inta_sequencer.sv
// rtl/inta_sequencer.sv - CPU-side two-pulse INTA sequencer with vector capture
//
// Purpose: watches the PIC INT line, issues the active-low two-pulse INTA
// sequence, captures the vector byte at the end of pulse 2 and offers it to
// the CPU over a valid/ready handshake, then idles for a recovery window.
//
// Ports:
//   clk    system clock, all state changes on the rising edge
//   rst_n  synchronous, active-low reset
//   bus    inta_sequencer_if.master (int_in, cpu_int_en, data_bus_in,
//          vector_ready in; inta_n, vector, vector_valid, busy out)
//
// Parameters:
//   PULSE_CYCLES    clocks inta_n is low per pulse (>=1)
//   GAP_CYCLES      clocks inta_n is high between the pulses (>=1)
//   RECOVER_CYCLES  idle clocks after acceptance before re-arming (>=1)
//
// Build option:
//   INTA_SYNC_EN  when defined, int_in passes through a 2-flop synchronizer
//                 (start latency +2 clocks); otherwise int_in must already
//                 be synchronous to clk.
module inta_sequencer #(
  parameter int PULSE_CYCLES   = 2,
  parameter int GAP_CYCLES     = 2,
  parameter int RECOVER_CYCLES = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  inta_sequencer_if.master  bus
);

  localparam int MAX_PG  = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int MAX_ALL = (MAX_PG > RECOVER_CYCLES) ? MAX_PG : RECOVER_CYCLES;
  localparam int CW      = $clog2(MAX_ALL) + 1;

  localparam logic [CW-1:0] PULSE_LD   = CW'(PULSE_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LD     = CW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] RECOVER_LD = CW'(RECOVER_CYCLES - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_P1_LOW  = 3'd1;
  localparam logic [2:0] S_GAP     = 3'd2;
  localparam logic [2:0] S_P2_LOW  = 3'd3;
  localparam logic [2:0] S_HOLD    = 3'd4;
  localparam logic [2:0] S_RECOVER = 3'd5;

  logic [2:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic          r_inta_n;
  logic [7:0]    r_vector;
  logic          r_valid;

  logic [2:0]    w_next;
  logic [CW-1:0] w_cnt_next;
  logic          w_int_q;
  logic          w_start;
  logic          w_cnt_zero;
  logic          w_capture;
  logic          w_accept;

`ifdef INTA_SYNC_EN
  logic r_sync1;
  logic r_sync2;

  // Two-flop synchronizer; a single-cycle int_in pulse still reaches r_sync2.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= bus.int_in;
      r_sync2 <= r_sync1;
    end
  end

  assign w_int_q = r_sync2;
`else
  assign w_int_q = bus.int_in;
`endif

  assign w_start    = w_int_q & bus.cpu_int_en;
  assign w_cnt_zero = (r_cnt == '0);

  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    w_capture  = 1'b0;
    w_accept   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_next     = S_P1_LOW;
          w_cnt_next = PULSE_LD;
        end
      end
      S_P1_LOW: begin
        if (w_cnt_zero) begin
          w_next     = S_GAP;
          w_cnt_next = GAP_LD;
        end else begin
          w_cnt_next = r_cnt - CW'(1);
        end
      end
      S_GAP: begin
        if (w_cnt_zero) begin
          w_next     = S_P2_LOW;
          w_cnt_next = PULSE_LD;
        end else begin
          w_cnt_next = r_cnt - CW'(1);
        end
      end
      S_P2_LOW: begin
        if (w_cnt_zero) begin
          w_next    = S_HOLD;
          w_capture = 1'b1;
        end else begin
          w_cnt_next = r_cnt - CW'(1);
        end
      end
      S_HOLD: begin
        if (bus.vector_ready) begin
          w_next     = S_RECOVER;
          w_cnt_next = RECOVER_LD;
          w_accept   = 1'b1;
        end
      end
      S_RECOVER: begin
        // The recovery window ends on this edge, which is also the first
        // edge the sequencer is re-armed: a pending request starts pulse 1
        // directly so back-to-back interrupts lose no extra clock.
        if (w_cnt_zero) begin
          if (w_start) begin
            w_next     = S_P1_LOW;
            w_cnt_next = PULSE_LD;
          end else begin
            w_next = S_IDLE;
          end
        end else begin
          w_cnt_next = r_cnt - CW'(1);
        end
      end
      default: begin
        w_next     = S_IDLE;
        w_cnt_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_inta_n <= 1'b1;
      r_vector <= 8'h00;
      r_valid  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      // Decoding the next state into a flop keeps inta_n glitch-free and
      // aligned with the state it belongs to.
      r_inta_n <= !((w_next == S_P1_LOW) || (w_next == S_P2_LOW));
      if (w_capture) begin
        r_vector <= bus.data_bus_in;
        r_valid  <= 1'b1;
      end else if (w_accept) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign bus.inta_n       = r_inta_n;
  assign bus.vector       = r_vector;
  assign bus.vector_valid = r_valid;
  assign bus.busy         = (r_state != S_IDLE);

endmodule

// File: tb/tb_inta_sequencer.sv
// tb/tb_inta_sequencer.sv - self-checking bench for inta_sequencer
module tb_inta_sequencer;
  localparam int P = 2;
  localparam int G = 2;
  localparam int R = 3;
`ifdef INTA_SYNC_EN
  localparam int SL = 2;
`else
  localparam int SL = 0;
`endif
  localparam int CAP = 2 * P + G;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  inta_sequencer_if bus ();

  inta_sequencer #(
    .PULSE_CYCLES  (P),
    .GAP_CYCLES    (G),
    .RECOVER_CYCLES(R)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: a sequence is a timeline anchored at its start edge.
  int         cyc = 0;
  bit         m_active = 0;
  int         m_s = 0;
  bit         m_acc = 0;
  int         m_acc_cyc = 0;
  logic [7:0] m_vec = 8'h00;
  logic       iq1 = 1'b0;
  logic       iq2 = 1'b0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic step();
    logic q;
    int   c;
    int   d;
    logic e_low;
    @(posedge clk);
    c = cyc;
`ifdef INTA_SYNC_EN
    q = iq2;
`else
    q = bus.int_in;
`endif
    if (!rst_n) begin
      m_active = 0;
      m_acc    = 0;
      m_vec    = 8'h00;
      iq1      = 1'b0;
      iq2      = 1'b0;
    end else begin
      iq2 = iq1;
      iq1 = bus.int_in;
      if (!m_active || (m_acc && c >= m_acc_cyc + R)) begin
        if (q && bus.cpu_int_en) begin
          m_active = 1;
          m_s      = c;
          m_acc    = 0;
        end else begin
          m_active = 0;
        end
      end else if (c == m_s + CAP) begin
        m_vec = bus.data_bus_in;
      end else if (c > m_s + CAP && !m_acc && bus.vector_ready) begin
        m_acc     = 1;
        m_acc_cyc = c;
      end
    end
    cyc++;
    #1;
    d     = c - m_s;
    e_low = m_active && ((d < P) || (d >= P + G && d < CAP));
    chk("inta_n", {7'd0, bus.inta_n}, {7'd0, !e_low});
    chk("vector_valid", {7'd0, bus.vector_valid},
        {7'd0, m_active && d >= CAP && !m_acc});
    chk("busy", {7'd0, bus.busy}, {7'd0, m_active});
    chk("vector", bus.vector, m_vec);
  endtask

  initial begin
    int k;
    bus.int_in       = 1'b1;
    bus.cpu_int_en   = 1'b1;
    bus.data_bus_in  = 8'h00;
    bus.vector_ready = 1'b0;
    rst_n            = 1'b0;

    // Reset held with a live request
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_inta_n", {7'd0, bus.inta_n}, 8'd1);
      chk("rst_vector", bus.vector, 8'h00);
      chk("rst_valid", {7'd0, bus.vector_valid}, 8'd0);
      chk("rst_busy", {7'd0, bus.busy}, 8'd0);
    end

    // Nominal sequence, vector 48, ready at relative edge 8
    #2;
    rst_n       = 1'b1;
    bus.int_in  = 1'b0;
    step();
    #2;
    bus.int_in      = 1'b1;
    bus.data_bus_in = 8'h48;
    for (int e = 0; e <= 12 + SL; e++) begin
      bus.vector_ready = (e == 8 + SL);
      step();
      #2;
      bus.int_in = 1'b0;
      if (e == SL)      chk("nom_p1_start", {7'd0, bus.inta_n}, 8'd0);
      if (e == SL + 2)  chk("nom_gap", {7'd0, bus.inta_n}, 8'd1);
      if (e == SL + 4)  chk("nom_p2_start", {7'd0, bus.inta_n}, 8'd0);
      if (e == SL + 6) begin
        chk("nom_vector", bus.vector, 8'h48);
        chk("nom_valid", {7'd0, bus.vector_valid}, 8'd1);
      end
      if (e == SL + 8)  chk("nom_valid_drop", {7'd0, bus.vector_valid}, 8'd0);
      if (e == SL + 10) chk("nom_busy_rec", {7'd0, bus.busy}, 8'd1);
      if (e == SL + 11) chk("nom_busy_idle", {7'd0, bus.busy}, 8'd0);
    end
    bus.vector_ready = 1'b0;

    // Enable gating
    bus.cpu_int_en = 1'b0;
    for (int i = 0; i < 20; i++) begin
      bus.int_in = 1'($urandom_range(0, 1));
      step();
      #2;
      chk("gate_inta_n", {7'd0, bus.inta_n}, 8'd1);
      chk("gate_busy", {7'd0, bus.busy}, 8'd0);
    end
    bus.int_in = 1'b1;
    for (int i = 0; i < SL; i++) begin
      step();
      #2;
    end
    bus.cpu_int_en = 1'b1;
    step();
    #2;
    chk("gate_start", {7'd0, bus.inta_n}, 8'd0);
    bus.int_in       = 1'b0;
    bus.vector_ready = 1'b1;
    bus.data_bus_in  = 8'($urandom);
    for (int i = 0; i < 16; i++) begin
      step();
      #2;
    end
    bus.vector_ready = 1'b0;

    // Request withdrawn during GAP; pulse 2 still issued
    bus.int_in      = 1'b1;
    bus.data_bus_in = 8'h4F;
    for (int e = 0; e <= SL + CAP + 2; e++) begin
      step();
      #2;
      if (e == SL + 2) bus.int_in = 1'b0;
    end
    chk("drop_vector", bus.vector, 8'h4F);
    chk("drop_valid", {7'd0, bus.vector_valid}, 8'd1);
    bus.vector_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      #2;
    end
    bus.vector_ready = 1'b0;

    // Reset on the second clock of pulse 2
    rst_n = 1'b0;
    step();
    #2;
    rst_n           = 1'b1;
    bus.int_in      = 1'b1;
    bus.data_bus_in = 8'hA5;
    for (int e = 0; e <= SL + 4; e++) begin
      step();
      #2;
    end
    chk("mid_in_p2", {7'd0, bus.inta_n}, 8'd0);
    rst_n = 1'b0;
    step();
    #2;
    chk("mid_rst_inta_n", {7'd0, bus.inta_n}, 8'd1);
    chk("mid_rst_valid", {7'd0, bus.vector_valid}, 8'd0);
    chk("mid_rst_vector", bus.vector, 8'h00);
    chk("mid_rst_busy", {7'd0, bus.busy}, 8'd0);
    rst_n = 1'b1;

    // Back-to-back with int_in held high
    bus.int_in      = 1'b1;
    bus.data_bus_in = 8'($urandom);
    k = 0;
    while (bus.vector_valid !== 1'b1 && k < 30) begin
      step();
      #2;
      k++;
    end
    chk("b2b_valid_wait", {7'd0, bus.vector_valid}, 8'd1);
    bus.vector_ready = 1'b1;
    step();
    #2;
    bus.vector_ready = 1'b0;
    step();
    #2;
    step();
    #2;
    chk("b2b_not_before_n3", {7'd0, bus.inta_n}, 8'd1);
    step();
    #2;
    chk("b2b_at_n3", {7'd0, bus.inta_n}, 8'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 500; i++) begin
      bus.int_in       = ($urandom_range(0, 3) != 0);
      bus.cpu_int_en   = ($urandom_range(0, 7) != 0);
      bus.vector_ready = ($urandom_range(0, 2) == 0);
      bus.data_bus_in  = 8'($urandom);
      rst_n            = ($urandom_range(0, 63) != 0);
      step();
      #2;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
